// File: rtl/ddfs_pkg.sv
// Shared constants and FSM encoding for the DDFS synthesizer and its frequency meter.
package ddfs_pkg;
  localparam int ACC_W    = 23;
  localparam int WIDTH    = 8;
  localparam int AVG_LOG2 = 4;
  localparam int DIV_LAT  = ACC_W + AVG_LOG2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_COUNT,
    ST_DIV,
    ST_DONE
  } state_t;
endpackage

// File: rtl/ddfs_seq_div.sv
// Restoring divider: quo = floor(2^QW / den), one quotient bit per clock after start.
module ddfs_seq_div #(
  parameter int DEN_W = 24,
  parameter int QW    = ddfs_pkg::DIV_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DEN_W-1:0] den,
  output logic [QW-1:0]    quo,
  output logic             done
);
  import ddfs_pkg::*;

  localparam int CW = $clog2(QW + 1);

  logic [DEN_W-1:0] rem_q, rem_d;
  logic [QW-1:0]    quo_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [DEN_W:0]   trial;
  logic             ge;

  // The dividend's leading one is preloaded into the remainder; only zeros shift in after it.
  // den must stay stable while the division runs.
  assign trial = {rem_q, 1'b0};
  assign ge    = trial >= {1'b0, den};
  assign rem_d = ge ? DEN_W'(trial - {1'b0, den}) : trial[DEN_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        busy_q <= 1'b1;
        cnt_q  <= CW'(QW);
        rem_q  <= DEN_W'(1);
        quo_q  <= '0;
      end else if (busy_q) begin
        rem_q <= rem_d;
        quo_q <= {quo_q[QW-2:0], ge};
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign quo  = quo_q;
  assign done = done_q;
endmodule

// File: rtl/ddfs_freq_meter.sv
// Measures the period of a sine sample stream over 2^AVG_LOG2 cycles and converts it
// into the DDFS tuning word that would produce that frequency.
module ddfs_freq_meter #(
  parameter int WIDTH    = ddfs_pkg::WIDTH,
  parameter int ACC_W    = ddfs_pkg::ACC_W,
  parameter int HYST     = 8,
  parameter int AVG_LOG2 = ddfs_pkg::AVG_LOG2,
  parameter int CNT_W    = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] samp,
  output logic [ACC_W-1:0]        fword,
  output logic                    valid,
  output logic                    busy,
  output logic                    ovf
);
  import ddfs_pkg::*;

  localparam int QW = ACC_W + AVG_LOG2;
  localparam logic signed [WIDTH-1:0] HYST_P   = WIDTH'(HYST);
  localparam logic signed [WIDTH-1:0] HYST_N   = WIDTH'(-HYST);
  localparam logic [CNT_W-1:0]        CNT_MAX  = '1;
  localparam logic [AVG_LOG2-1:0]     PER_LAST = '1;

  logic signed [WIDTH-1:0] s_q;
  logic                    neg_q, neg_d, evt;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        clk_cnt_q, clk_cnt_d;
  logic [AVG_LOG2-1:0]     per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]        c_q, c_d;
  logic                    go_q, go_d;
  logic [ACC_W-1:0]        fword_q, fword_d;
  logic                    ovf_q, ovf_d;
  logic [QW-1:0]           div_quo;
  logic                    div_done;
  logic                    unused_quo_hi;

  // Input stage: registered sample and hysteresis-armed rising-crossing detector
  always_ff @(posedge clk) begin
    s_q <= samp;
    c_q <= c_d;
  end

  always_comb begin
    evt   = neg_q && (s_q >= HYST_P);
    neg_d = neg_q;
    if (evt)                 neg_d = 1'b0;
    else if (s_q <= HYST_N)  neg_d = 1'b1;
  end

  // Control: the timeout wins over a crossing so C never exceeds the divisor width
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    per_cnt_d = per_cnt_q;
    c_d       = c_q;
    go_d      = 1'b0;
    fword_d   = fword_q;
    ovf_d     = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SYNC;
          clk_cnt_d = '0;
          per_cnt_d = '0;
        end
      end
      ST_SYNC: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (clk_cnt_q == CNT_MAX) begin
          state_d = ST_DONE;
          fword_d = '0;
          ovf_d   = 1'b1;
        end else if (evt) begin
          state_d   = ST_COUNT;
          clk_cnt_d = '0;
          per_cnt_d = '0;
        end
      end
      ST_COUNT: begin
        clk_cnt_d = clk_cnt_q + 1'b1;
        if (clk_cnt_q == CNT_MAX) begin
          state_d = ST_DONE;
          fword_d = '0;
          ovf_d   = 1'b1;
        end else if (evt) begin
          per_cnt_d = per_cnt_q + 1'b1;
          if (per_cnt_q == PER_LAST) begin
            c_d     = clk_cnt_q + 1'b1;
            go_d    = 1'b1;
            state_d = ST_DIV;
          end
        end
      end
      ST_DIV: begin
        if (div_done) begin
          state_d = ST_DONE;
          fword_d = div_quo[ACC_W-1:0];
          ovf_d   = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_q     <= 1'b0;
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      per_cnt_q <= '0;
      go_q      <= 1'b0;
      fword_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      neg_q     <= neg_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      per_cnt_q <= per_cnt_d;
      go_q      <= go_d;
      fword_q   <= fword_d;
      ovf_q     <= ovf_d;
    end
  end

  // Divide stage: started one cycle after C is latched
  ddfs_seq_div #(
    .DEN_W(CNT_W),
    .QW   (QW)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(go_q),
    .den  (c_q),
    .quo  (div_quo),
    .done (div_done)
  );

  // Quotient never exceeds 2^(ACC_W-1) because C is at least the Nyquist count.
  assign unused_quo_hi = ^div_quo[QW-1:ACC_W];

  assign fword = fword_q;
  assign ovf   = ovf_q;
  assign valid = (state_q == ST_DONE);
  assign busy  = (state_q == ST_SYNC) || (state_q == ST_COUNT) || (state_q == ST_DIV);
endmodule

// File: tb/tb_ddfs_freq_meter.sv
// Directed bench for ddfs_freq_meter: DDFS tones, Nyquist square, timeout and reset aborts.
module tb_ddfs_freq_meter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, start_t;
  logic signed [7:0] samp;
  logic [22:0]       fword, fword_t;
  logic              valid, busy, ovf, valid_t, busy_t, ovf_t;

  ddfs_freq_meter dut (
    .clk(clk), .rst(rst), .start(start), .samp(samp),
    .fword(fword), .valid(valid), .busy(busy), .ovf(ovf)
  );

  ddfs_freq_meter #(.CNT_W(12)) dut_t (
    .clk(clk), .rst(rst), .start(start_t), .samp(samp),
    .fword(fword_t), .valid(valid_t), .busy(busy_t), .ovf(ovf_t)
  );

  int          nassert = 0;
  int          nfail   = 0;
  int          cyc     = 0;
  int          mode    = 0;
  logic [22:0] phase   = '0;
  logic [22:0] finc    = '0;
  bit          alt     = 1'b0;
  bit          mneg    = 1'b0;
  bit          meas    = 1'b0;
  int          nev, term_edge, acc_t, d;
  int          nval, vcyc, nval_t, vcyc_t;
  logic [22:0] vfw, vfw_t;
  logic        vovf, vovf_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [7:0] sine(input logic [22:0] ph);
    real a;
    a = 127.0 * $sin(6.283185307179586 * real'(ph) / 8388608.0);
    return 8'($rtoi(a));
  endfunction

  task automatic gen(output logic signed [7:0] s);
    case (mode)
      1: begin phase = phase + finc; s = sine(phase); end
      2: begin alt = ~alt; s = alt ? 8'sd100 : -8'sd100; end
      default: s = 8'sd0;
    endcase
  endtask

  // One clock: drive inputs, track the crossing model, then sample outputs 1ns after the edge.
  task automatic tick(input logic signed [7:0] s, input logic st, input logic st_t);
    bit ev;
    samp = s; start = st; start_t = st_t;
    @(posedge clk);
    cyc++;
    if (rst) mneg = 1'b0;
    else begin
      ev = mneg && (s >= 8);
      if (ev) mneg = 1'b0;
      else if (s <= -8) mneg = 1'b1;
      if (ev && meas) begin
        nev++;
        if (nev == 17) begin term_edge = cyc; meas = 1'b0; end
      end
    end
    #1;
    start = 1'b0; start_t = 1'b0;
    if (valid === 1'b1) begin
      nval++; vcyc = cyc; vfw = fword; vovf = ovf;
      chk("busy_low_at_valid", {31'd0, busy}, 32'd0);
    end
    if (valid_t === 1'b1) begin
      nval_t++; vcyc_t = cyc; vfw_t = fword_t; vovf_t = ovf_t;
      chk("busy_t_low_at_valid", {31'd0, busy_t}, 32'd0);
    end
  endtask

  task automatic cycles(input int n);
    logic signed [7:0] s;
    for (int i = 0; i < n; i++) begin gen(s); tick(s, 1'b0, 1'b0); end
  endtask

  task automatic meas_start();
    logic signed [7:0] s;
    nev = 0; meas = 1'b1; nval = 0; term_edge = -100000;
    gen(s); tick(s, 1'b1, 1'b0);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic check_result(input string tag, input logic [22:0] exp_fw);
    chk({tag, "_nvalid"}, nval, 32'd1);
    chk({tag, "_fword"}, {9'd0, vfw}, {9'd0, exp_fw});
    chk({tag, "_ovf"}, {31'd0, vovf}, 32'd0);
    chk({tag, "_latency"}, vcyc - term_edge, 32'd30);
  endtask

  initial begin
    logic signed [7:0] s;
    rst = 1'b1; start = 1'b0; start_t = 1'b0; samp = '0;
    nval = 0; nval_t = 0; vcyc = 0; vcyc_t = 0; vfw = '0; vfw_t = '0; vovf = 1'b0; vovf_t = 1'b0;
    nev = 0; term_edge = -100000; acc_t = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_fword", {9'd0, fword}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_ovf_t", {31'd0, ovf_t}, 32'd0);
    rst = 1'b0;
    cycles(4);

    // Tone 2^15: period 256, C=4096
    mode = 1; finc = 23'd1 << 15;
    cycles(40);
    meas_start();
    cycles(4800);
    check_result("tone15", 23'd32768);

    // Tone 2^13 with a second start while counting
    finc = 23'd1 << 13;
    cycles(50);
    meas_start();
    cycles(3000);
    gen(s); tick(s, 1'b1, 1'b0);
    chk("busy_during_count", {31'd0, busy}, 32'd1);
    cycles(17000);
    check_result("tone13", 23'd8192);

    // Alternating +100/-100: Nyquist limit, C=32
    mode = 2;
    cycles(4);
    meas_start();
    cycles(100);
    check_result("nyquist", 23'd4194304);
    chk("fword_held", {9'd0, fword}, 32'd4194304);

    // Timeout on the short-counter instance with silent input
    mode = 0;
    cycles(4);
    nval_t = 0;
    tick(8'sd0, 1'b0, 1'b1);
    acc_t = cyc;
    chk("busy_t_after_start", {31'd0, busy_t}, 32'd1);
    cycles(4200);
    d = vcyc_t - acc_t;
    chk("timeout_nvalid", nval_t, 32'd1);
    chk("timeout_fword", {9'd0, vfw_t}, 32'd0);
    chk("timeout_ovf", {31'd0, vovf_t}, 32'd1);
    chk("timeout_ovf_held", {31'd0, ovf_t}, 32'd1);
    chk("timeout_latency", {31'd0, (d >= 4095 && d <= 4097)}, 32'd1);

    // Good measurement on the same instance clears ovf: period 128, C=2048
    mode = 1; finc = 23'd1 << 16;
    cycles(50);
    nval_t = 0;
    gen(s); tick(s, 1'b0, 1'b1);
    cycles(2400);
    chk("recover_nvalid", nval_t, 32'd1);
    chk("recover_fword", {9'd0, vfw_t}, 32'd65536);
    chk("recover_ovf", {31'd0, vovf_t}, 32'd0);
    chk("recover_ovf_held", {31'd0, ovf_t}, 32'd0);

    // Asynchronous reset mid-cycle clears outputs without a clock edge
    meas_start();
    cycles(10);
    #3;
    rst = 1'b1; mneg = 1'b0; meas = 1'b0;
    #1;
    chk("arst_fword", {9'd0, fword}, 32'd0);
    chk("arst_valid", {31'd0, valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ovf", {31'd0, ovf}, 32'd0);
    chk("arst_fword_t", {9'd0, fword_t}, 32'd0);
    mode = 0;
    cycles(3);
    rst = 1'b0;
    cycles(3);

    // Reset during the divide aborts it; a fresh start measures normally
    mode = 1; finc = 23'd1 << 15;
    cycles(40);
    meas_start();
    for (int i = 0; i < 6000 && meas; i++) begin gen(s); tick(s, 1'b0, 1'b0); end
    cycles(10);
    chk("busy_in_div", {31'd0, busy}, 32'd1);
    #3;
    rst = 1'b1; mneg = 1'b0; meas = 1'b0;
    mode = 0;
    cycles(3);
    rst = 1'b0;
    cycles(3);
    mode = 1;
    cycles(60);
    chk("abort_no_valid", nval, 32'd0);
    meas_start();
    cycles(4800);
    check_result("after_abort", 23'd32768);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
